// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch AXI read front end.
package ifu_fetch_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } ar_state_e;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam int         FETCH_ALIGN_W = 3;

  // One in-flight fetch: the PC exactly as captured plus a drop-on-return flag.
  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } fetch_tag_t;

  function automatic logic [31:0] align_pc(logic [31:0] pc);
    return {pc[31:FETCH_ALIGN_W], {FETCH_ALIGN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ifu_fetch_tag_fifo.sv
// In-order tag FIFO pairing AXI R beats with the PCs that requested them.
module ifu_fetch_tag_fifo
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [32:0] push_data,
  input  logic        pop,
  input  logic        set_stale,
  output logic [32:0] head,
  output logic        empty,
  output logic [2:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] nxt(logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign head  = mem[rd_ptr];
  assign empty = (count == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Broadcast first so a same-cycle push below still lands with stale set.
      if (set_stale)
        for (int i = 0; i < DEPTH; i++) mem[i][0] <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= {push_data[32:1], push_data[0] | set_stale};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: issues aligned AXI AR requests from the PC register and
// turns in-order R beats into fetch packets, dropping anything from before a redirect.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  input  logic        stall_i,
  output logic        pc_adv_o,
  output logic        m_arvalid_o,
  output logic [31:0] m_araddr_o,
  input  logic        m_arready_i,
  input  logic        m_rvalid_i,
  input  logic [63:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i,
  output logic        m_rready_o,
  output logic        inst_valid_o,
  output logic [63:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o,
  input  logic        inst_ready_i
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  ar_state_e   state;
  logic [31:0] ar_pc;
  logic        ar_stale;
  logic [2:0]  outstanding;
  logic        fifo_empty;
  logic [32:0] head_raw;
  fetch_tag_t  head_tag, push_tag;
  logic        ar_hs, r_hs, can_fetch, cap_idle, cap_b2b, accept;

  assign head_tag  = fetch_tag_t'(head_raw);
  assign push_tag  = '{pc: ar_pc, stale: ar_stale | jump_flag_i};

  assign ar_hs     = (state == ST_REQ) && m_arready_i;
  assign can_fetch = !jump_flag_i && !stall_i;
  assign cap_idle  = (state == ST_IDLE) && can_fetch && (outstanding < MAX_CNT);
  // The request being handshaken now counts against the limit.
  assign cap_b2b   = ar_hs && can_fetch && ((outstanding + 3'd1) < MAX_CNT);

  // Combinational so the PC register advances in the capture cycle; held low in reset.
  assign pc_adv_o    = rst_n && (cap_idle || cap_b2b);
  assign m_arvalid_o = (state == ST_REQ);
  assign m_araddr_o  = align_pc(ar_pc);

  assign m_rready_o = (!fifo_empty && head_tag.stale) || !inst_valid_o || inst_ready_i;
  assign r_hs       = m_rvalid_i && m_rready_o && !fifo_empty;
  assign accept     = r_hs && !head_tag.stale && !jump_flag_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ar_pc    <= '0;
      ar_stale <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cap_idle) begin
          state    <= ST_REQ;
          ar_pc    <= pc_i;
          ar_stale <= 1'b0;
        end
        ST_REQ: begin
          if (ar_hs) begin
            ar_stale <= 1'b0;
            if (cap_b2b) ar_pc <= pc_i;
            else         state <= ST_IDLE;
          end else if (jump_flag_i) begin
            // Request stays on the bus; its data is dropped on return.
            ar_stale <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ifu_fetch_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ar_hs),
    .push_data (push_tag),
    .pop       (r_hs),
    .set_stale (jump_flag_i),
    .head      (head_raw),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_o <= 1'b0;
      inst_data_o  <= '0;
      inst_pc_o    <= '0;
      inst_err_o   <= 1'b0;
    end else if (jump_flag_i) begin
      inst_valid_o <= 1'b0;
      inst_data_o  <= '0;
      inst_pc_o    <= '0;
      inst_err_o   <= 1'b0;
    end else if (accept) begin
      inst_valid_o <= 1'b1;
      inst_data_o  <= m_rdata_i;
      inst_pc_o    <= head_tag.pc;
      inst_err_o   <= (m_rresp_i != RESP_OKAY);
    end else if (inst_ready_i) begin
      inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized bench for ifu_fetch_ctrl with a queue-based fetch model and an AXI slave model.
`timescale 1ns/1ps
module tb_ifu_fetch_ctrl;
  localparam int MAX = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic jump_flag_i = 0, stall_i = 0, m_arready_i = 0, m_rvalid_i = 0, inst_ready_i = 0;
  logic [63:0] m_rdata_i = '0;
  logic [1:0]  m_rresp_i = '0;
  logic pc_adv_o, m_arvalid_o, m_rready_o, inst_valid_o, inst_err_o;
  logic [31:0] m_araddr_o, inst_pc_o;
  logic [63:0] inst_data_o;
  logic b_pc_adv, b_arvalid, b_rready, b_inst_valid, b_inst_err;
  logic [31:0] b_araddr, b_inst_pc;
  logic [63:0] b_inst_data;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .jump_flag_i(jump_flag_i), .stall_i(stall_i),
    .pc_adv_o(pc_adv_o), .m_arvalid_o(m_arvalid_o), .m_araddr_o(m_araddr_o),
    .m_arready_i(m_arready_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rready_o(m_rready_o), .inst_valid_o(inst_valid_o),
    .inst_data_o(inst_data_o), .inst_pc_o(inst_pc_o), .inst_err_o(inst_err_o),
    .inst_ready_i(inst_ready_i));

  // Default-depth instance, shares the input pins; only its issue count is checked.
  ifu_fetch_ctrl dut2 (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .jump_flag_i(jump_flag_i), .stall_i(stall_i),
    .pc_adv_o(b_pc_adv), .m_arvalid_o(b_arvalid), .m_araddr_o(b_araddr),
    .m_arready_i(m_arready_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rready_o(b_rready), .inst_valid_o(b_inst_valid),
    .inst_data_o(b_inst_data), .inst_pc_o(b_inst_pc), .inst_err_o(b_inst_err),
    .inst_ready_i(inst_ready_i));

  typedef struct { logic [31:0] pc; bit stale; } tag_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; int rdy; } beat_t;
  tag_t tags[$];
  beat_t sq[$];
  logic [31:0] ar_log[$];
  logic [32:0] inst_log[$];

  bit held, held_stale, ov, oerr;
  logic [31:0] held_pc, opc;
  logic [63:0] od;

  bit d_rst_n, d_jump, d_stall, d_arready, d_iready, r_hold, spur_en, bad_next;
  int lat_min = 2, lat_rnd = 0;
  logic [31:0] pc_reg, jump_tgt;
  int cyc, checks, errs, adv_cnt, b_hs_cnt, b_adv_cnt;
  bit s_pc_adv, s_arvalid;
  logic [31:0] s_araddr;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [32:0] inst_at(int i);
    return (i < inst_log.size()) ? inst_log[i] : 33'h1_FFFF_FFFF;
  endfunction
  function automatic logic [31:0] ar_at(int i);
    return (i < ar_log.size()) ? ar_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    bit e_cap, e_rready, r_hs, ar_hs, load;
    tag_t t;
    logic [31:0] tmp;
    @(negedge clk);
    rst_n = d_rst_n;
    if (!d_rst_n) begin
      tags.delete(); sq.delete();
      held = 0; held_stale = 0; held_pc = '0; ov = 0; od = '0; opc = '0; oerr = 0;
    end
    pc_i = pc_reg; jump_flag_i = d_jump; stall_i = d_stall;
    m_arready_i = d_arready; inst_ready_i = d_iready;
    if (sq.size() > 0 && !r_hold && cyc >= sq[0].rdy) begin
      m_rvalid_i = 1; m_rdata_i = sq[0].data; m_rresp_i = sq[0].resp;
    end else if (spur_en && sq.size() == 0 && $urandom_range(0, 9) == 0) begin
      m_rvalid_i = 1; m_rdata_i = {$urandom, $urandom}; m_rresp_i = 2'($urandom_range(0, 3));
    end else begin
      m_rvalid_i = 0; m_rdata_i = '0; m_rresp_i = '0;
    end
    #1;
    e_cap = d_rst_n && !d_jump && !d_stall &&
            (held ? (d_arready && tags.size() + 1 < MAX) : (tags.size() < MAX));
    e_rready = (tags.size() > 0 && tags[0].stale) || !ov || d_iready;
    chk("pc_adv", pc_adv_o, e_cap);
    chk("arvalid", m_arvalid_o, held);
    if (held || !d_rst_n) chk("araddr", m_araddr_o, {held_pc[31:3], 3'b000});
    chk("rready", m_rready_o, e_rready);
    chk("inst_valid", inst_valid_o, ov);
    if (ov || !d_rst_n) begin
      chk("inst_data", inst_data_o, od);
      chk("inst_pc", inst_pc_o, opc);
      chk("inst_err", inst_err_o, oerr);
    end
    s_pc_adv = pc_adv_o; s_arvalid = m_arvalid_o; s_araddr = m_araddr_o;
    if (pc_adv_o) adv_cnt++;
    if (b_pc_adv) b_adv_cnt++;
    if (b_arvalid && m_arready_i) b_hs_cnt++;
    if (m_arvalid_o && m_arready_i) ar_log.push_back(m_araddr_o);
    if (inst_valid_o && inst_ready_i) inst_log.push_back({inst_err_o, inst_pc_o});
    if (d_rst_n) begin
      r_hs  = m_rvalid_i && e_rready && tags.size() > 0;
      ar_hs = held && d_arready;
      load  = 0;
      if (r_hs) begin
        t = tags.pop_front();
        void'(sq.pop_front());
        load = !t.stale && !d_jump;
      end
      if (ar_hs) begin
        tags.push_back(tag_t'{held_pc, held_stale || d_jump});
        sq.push_back(beat_t'{{$urandom, $urandom},
                     bad_next ? 2'b10 : ((spur_en && $urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00),
                     cyc + lat_min + int'($urandom_range(0, lat_rnd))});
        bad_next = 0;
        held = 0;
      end
      if (d_jump) begin
        foreach (tags[k]) tags[k].stale = 1;
        if (held) held_stale = 1;
      end
      if (e_cap) begin held = 1; held_pc = pc_reg; held_stale = 0; end
      if (d_jump) begin ov = 0; od = '0; opc = '0; oerr = 0; end
      else if (load) begin ov = 1; od = m_rdata_i; opc = t.pc; oerr = (m_rresp_i != 2'b00); end
      else if (d_iready) ov = 0;
      if (d_jump) pc_reg = jump_tgt;
      else if (e_cap) begin tmp = pc_reg & 32'hFFFF_FFF8; pc_reg = tmp + 32'd8; end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic reset_dut();
    d_rst_n = 0; d_jump = 0; d_stall = 0; r_hold = 0; bad_next = 0;
    step(); step();
    d_rst_n = 1;
    ar_log.delete(); inst_log.delete();
    adv_cnt = 0; b_hs_cnt = 0; b_adv_cnt = 0;
  endtask

  initial begin
    logic [31:0] tmp;
    d_arready = 1; d_iready = 1;
    pc_reg = 32'h8000_0000;
    reset_dut();
    repeat (12) step();
    chk("s031_ar0", ar_at(0), 32'h8000_0000);
    chk("s031_ar1", ar_at(1), 32'h8000_0008);
    chk("s031_inst0", inst_at(0), {1'b0, 32'h8000_0000});
    chk("s031_inst1", inst_at(1), {1'b0, 32'h8000_0008});

    pc_reg = 32'h8000_0004;
    reset_dut();
    repeat (10) step();
    chk("s032_ar0", ar_at(0), 32'h8000_0000);
    chk("s032_ar1", ar_at(1), 32'h8000_0008);
    chk("s032_inst0", inst_at(0), {1'b0, 32'h8000_0004});

    pc_reg = 32'h8000_1000;
    reset_dut();
    d_arready = 0;
    step();
    chk("s033_capture", s_pc_adv, 1'b1);
    repeat (5) begin
      step();
      chk("s033_araddr", s_araddr, 32'h8000_1000);
      chk("s033_arvalid", s_arvalid, 1'b1);
      chk("s033_pc_adv", s_pc_adv, 1'b0);
    end
    chk("s033_no_hs", ar_log.size(), 0);
    d_arready = 1;
    step();
    chk("s033_hs", ar_log.size(), 1);

    pc_reg = 32'h8000_2000;
    reset_dut();
    r_hold = 1;
    repeat (10) step();
    chk("s035_hs_max2", b_hs_cnt, 2);
    chk("s035_adv_max2", b_adv_cnt, 2);
    chk("s035_hs_max3", ar_log.size(), MAX);
    chk("s035_adv_max3", adv_cnt, MAX);
    r_hold = 0;
    repeat (4) step();
    chk("s035_resume_max2", b_adv_cnt > 2, 1'b1);
    chk("s035_resume_max3", adv_cnt > MAX, 1'b1);

    pc_reg = 32'h8000_3000;
    reset_dut();
    r_hold = 1;
    repeat (3) step();
    d_arready = 0; d_jump = 1; jump_tgt = 32'h8000_4000;
    step();
    d_jump = 0; d_arready = 1; r_hold = 0;
    repeat (20) step();
    chk("s034_first_after_jump", inst_at(0), {1'b0, 32'h8000_4000});

    pc_reg = 32'h8000_5000;
    reset_dut();
    bad_next = 1;
    repeat (12) step();
    chk("s036_err", inst_at(0), {1'b1, 32'h8000_5000});
    chk("s036_okay", inst_at(1), {1'b0, 32'h8000_5008});

    spur_en = 1; lat_min = 1; lat_rnd = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) reset_dut();
      d_jump = ($urandom_range(0, 19) == 0);
      tmp = $urandom;
      jump_tgt = tmp & 32'hFFFF_FFFC;
      d_stall = ($urandom_range(0, 4) == 0);
      d_arready = ($urandom_range(0, 9) < 6);
      d_iready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
